// File: rtl/mito_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mito_pkg                                                                |
// | Shared FSM type and round/saturate helpers for the quantizing stages.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package mito_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } baq_state_t;

    // Helpers work at a fixed wide width; callers sign-extend in and truncate out.
    localparam int MATH_W = 64;

    // Round-half-up arithmetic right shift.
    function automatic logic signed [MATH_W-1:0] round_shift(
        input logic signed [MATH_W-1:0] x,
        input logic        [4:0]        sh
    );
        logic signed [MATH_W-1:0] half;
        half = (sh == 5'd0) ? '0 : (64'sd1 <<< (sh - 5'd1));
        return (x + half) >>> sh;
    endfunction

    // Clamp to the range of a signed value of width w.
    function automatic logic signed [MATH_W-1:0] saturate(
        input logic signed [MATH_W-1:0] x,
        input int                       w
    );
        logic signed [MATH_W-1:0] hi;
        logic signed [MATH_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_round_shift.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sat_round_shift                                                         |
// | Two pipeline stages: optional ReLU + round/shift, then saturation.      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module sat_round_shift
    import mito_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic signed [IN_W-1:0]  in_sum,
    input  logic        [4:0]       shift,
    input  logic                    relu_en,
    output logic                    mid_valid,
    output logic                    out_valid,
    output logic                    out_last,
    output logic signed [OUT_W-1:0] out_data
);

    logic signed [IN_W-1:0] w_relu;
    logic signed [IN_W:0]   r_mid;
    logic                   r_mid_last;

    assign w_relu = (relu_en && in_sum[IN_W-1]) ? '0 : in_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_valid  <= 1'b0;
            r_mid_last <= 1'b0;
            r_mid      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else if (en) begin
            mid_valid  <= in_valid;
            r_mid_last <= in_last;
            // One extra bit of headroom covers the rounding increment.
            r_mid      <= (IN_W+1)'(round_shift(MATH_W'(w_relu), shift));
            out_valid  <= mid_valid;
            out_last   <= r_mid_last;
            out_data   <= OUT_W'(saturate(MATH_W'(r_mid), OUT_W));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bias_add_quant.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bias_add_quant                                                          |
// | Adds per-channel bias to MAC sums, quantizes, drives bias_read control. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module bias_add_quant
    import mito_pkg::*;
#(
    parameter int ACC_WIDTH  = 24,
    parameter int BIAS_WIDTH = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int PIX_W      = 16,
    parameter int CH_W       = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic        [PIX_W-1:0]     num_pixels,
    input  logic        [CH_W-1:0]      num_channels,
    input  logic        [4:0]           shift,
    input  logic                        relu_en,
    output logic                        bias_read,
    input  logic signed [BIAS_WIDTH-1:0] bias_in,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    input  logic signed [ACC_WIDTH-1:0] acc_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    baq_state_t r_state;
    baq_state_t w_next;

    logic [PIX_W-1:0]         r_num_pixels;
    logic [CH_W-1:0]          r_num_channels;
    logic [4:0]               r_shift;
    logic                     r_relu_en;
    logic [PIX_W-1:0]         r_pix;
    logic [CH_W-1:0]          r_ch;
    logic                     r_zero_done;
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic signed [ACC_WIDTH:0] r_s1_sum;

    logic w_en;
    logic w_xfer;
    logic w_last_pix;
    logic w_last_ch;
    logic w_empty;
    logic w_mid_valid;
    logic w_start_ok;

    assign w_en       = !out_valid || out_ready;
    assign acc_ready  = (r_state == RUN) && w_en;
    assign w_xfer     = acc_valid && acc_ready;
    assign w_last_pix = (r_pix == r_num_pixels - PIX_W'(1));
    assign w_last_ch  = (r_ch == r_num_channels - CH_W'(1));
    assign w_empty    = !r_s1_valid && !w_mid_valid && !out_valid;
    assign w_start_ok = (num_pixels != '0) && (num_channels != '0);

    assign busy      = (r_state != IDLE);
    assign bias_read = (r_state != LOAD);
    assign done      = r_zero_done || ((r_state == DRAIN) && w_empty);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && w_start_ok) w_next = LOAD;
            LOAD:    w_next = RUN;
            RUN:     if (w_xfer && w_last_pix) w_next = w_last_ch ? DRAIN : LOAD;
            DRAIN:   if (w_empty) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_num_pixels   <= '0;
            r_num_channels <= '0;
            r_shift        <= '0;
            r_relu_en      <= 1'b0;
            r_pix          <= '0;
            r_ch           <= '0;
            r_zero_done    <= 1'b0;
        end else begin
            r_state     <= w_next;
            // A degenerate job completes immediately with no data.
            r_zero_done <= (r_state == IDLE) && start && !w_start_ok;
            if ((r_state == IDLE) && start) begin
                r_num_pixels   <= num_pixels;
                r_num_channels <= num_channels;
                r_shift        <= shift;
                r_relu_en      <= relu_en;
                r_pix          <= '0;
                r_ch           <= '0;
            end else if (w_xfer) begin
                if (w_last_pix) begin
                    r_pix <= '0;
                    if (!w_last_ch) r_ch <= r_ch + CH_W'(1);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_xfer;
            r_s1_last  <= w_xfer && w_last_pix && w_last_ch;
            r_s1_sum   <= (ACC_WIDTH+1)'(acc_data) + (ACC_WIDTH+1)'(bias_in);
        end
    end

    sat_round_shift #(
        .IN_W  (ACC_WIDTH + 1),
        .OUT_W (OUT_WIDTH)
    ) u_sat_round_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_en),
        .in_valid  (r_s1_valid),
        .in_last   (r_s1_last),
        .in_sum    (r_s1_sum),
        .shift     (r_shift),
        .relu_en   (r_relu_en),
        .mid_valid (w_mid_valid),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_bias_add_quant.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_bias_add_quant                                                       |
// | Directed bench: bias buffer model, job driver, hand-computed results.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_bias_add_quant;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        num_pixels;
    logic [9:0]         num_channels;
    logic [4:0]         shift;
    logic               relu_en;
    logic               bias_read;
    logic signed [7:0]  bias_in;
    logic               acc_valid;
    logic               acc_ready;
    logic signed [23:0] acc_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               out_last;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_v[$];
    int bias_v[$];
    int exp_v[$];
    int bias_idx;

    bias_add_quant dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_pixels   (num_pixels),
        .num_channels (num_channels),
        .shift        (shift),
        .relu_en      (relu_en),
        .bias_read    (bias_read),
        .bias_in      (bias_in),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_data     (acc_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Bias buffer: loads the next channel's bias whenever bias_read is low.
    always @(posedge clk) begin
        if (start && !busy) begin
            bias_idx <= 0;
        end else if (!bias_read && bias_idx < bias_v.size()) begin
            bias_in  <= 8'(bias_v[bias_idx]);
            bias_idx <= bias_idx + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Runs one job; exp_cycles>0 checks the cycle at which done appears,
    // rst_at>0 pulls reset at that cycle and checks the job is abandoned.
    task automatic run_job(input int np, input int nc, input int sh, input int relu,
                           input int exp_cycles, input int stall_from, input int stall_len,
                           input int rst_at);
        int ai = 0;
        int oi = 0;
        int loads = 0;
        int cyc = 0;
        bit fin = 1'b0;
        bit prev_stall = 1'b0;
        int prev_data = 0;
        @(negedge clk);
        start        = 1'b1;
        num_pixels   = 16'(np);
        num_channels = 10'(nc);
        shift        = 5'(sh);
        relu_en      = (relu != 0);
        while (!fin && cyc < 200) begin
            cyc++;
            @(negedge clk);
            start = (cyc == 3);
            if (cyc == 3) begin
                num_pixels   = 16'd1;
                num_channels = 10'd1;
                shift        = 5'd7;
                relu_en      = 1'b1;
            end
            acc_valid = (ai < acc_v.size());
            acc_data  = acc_valid ? 24'(acc_v[ai]) : 24'sd0;
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_bias_read", int'(bias_read), 1);
                check_eq("rst_acc_ready", int'(acc_ready), 0);
                check_eq("rst_out_valid", int'(out_valid), 0);
                check_eq("rst_out_last", int'(out_last), 0);
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_done", int'(done), 0);
                check_eq("rst_out_data", int'(out_data), 0);
                @(negedge clk);
                rst_n     = 1'b1;
                start     = 1'b0;
                acc_valid = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    #1;
                    check_eq("post_rst_done", int'(done), 0);
                    check_eq("post_rst_out_valid", int'(out_valid), 0);
                end
                return;
            end
            #1;
            if (!bias_read) loads++;
            if (out_valid && !out_ready) begin
                check_eq("stall_acc_ready", int'(acc_ready), 0);
                if (prev_stall) check_eq("stall_out_data", int'(out_data), prev_data);
                prev_data  = int'(out_data);
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (acc_valid && acc_ready) ai++;
            if (out_valid && out_ready) begin
                if (oi < exp_v.size()) begin
                    check_eq($sformatf("out_data[%0d]", oi), int'(out_data), exp_v[oi]);
                    check_eq($sformatf("out_last[%0d]", oi), int'(out_last),
                             (oi == exp_v.size() - 1) ? 1 : 0);
                end else begin
                    check_eq("extra_beat", oi, exp_v.size() - 1);
                end
                oi++;
            end
            if (done) begin
                fin = 1'b1;
                if (exp_cycles > 0) check_eq("done_cycle", cyc, exp_cycles);
            end
        end
        check_eq("done_seen", int'(fin), 1);
        check_eq("beat_count", oi, exp_v.size());
        check_eq("load_cycles", loads, nc);
        @(negedge clk);
        start     = 1'b0;
        acc_valid = 1'b0;
        #1;
        check_eq("done_single_pulse", int'(done), 0);
        check_eq("idle_after_job", int'(busy), 0);
    endtask

    task automatic run_zero_job();
        @(negedge clk);
        start        = 1'b1;
        num_pixels   = 16'd0;
        num_channels = 10'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check_eq($sformatf("zero_done[%0d]", c), int'(done), (c == 1) ? 1 : 0);
            check_eq("zero_out_valid", int'(out_valid), 0);
            check_eq("zero_busy", int'(busy), 0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_pixels   = '0;
        num_channels = '0;
        shift        = '0;
        relu_en      = 1'b0;
        bias_in      = '0;
        acc_valid    = 1'b0;
        acc_data     = '0;
        out_ready    = 1'b1;
        bias_idx     = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_bias_read", int'(bias_read), 1);
        check_eq("reset_acc_ready", int'(acc_ready), 0);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_out_last", int'(out_last), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, single channel.
        bias_v = '{5};
        acc_v  = '{10, -20};
        exp_v  = '{15, -15};
        run_job(2, 1, 0, 0, 7, 0, 0, 0);

        // Saturation and round-half-up.
        bias_v = '{0};
        acc_v  = '{1000, -1000, 6, -6};
        exp_v  = '{127, -128, 2, -1};
        run_job(4, 1, 2, 0, 9, 0, 0, 0);

        // ReLU across two single-pixel channels.
        bias_v = '{10, -10};
        acc_v  = '{-50, 40};
        exp_v  = '{0, 30};
        run_job(1, 2, 0, 1, 8, 0, 0, 0);

        // Channel switch: bias 1 then 100, one LOAD bubble.
        bias_v = '{1, 100};
        acc_v  = '{0, 1, -2, 3, -4, 5};
        exp_v  = '{1, 2, -1, 103, 96, 105};
        run_job(3, 2, 0, 0, 12, 0, 0, 0);

        // Backpressure for 5 cycles mid-stream, shift 1.
        bias_v = '{3};
        acc_v  = '{1, 2, 3, 4, 5, 6};
        exp_v  = '{2, 3, 3, 4, 4, 5};
        run_job(6, 1, 1, 0, 0, 5, 5, 0);

        run_zero_job();

        // Reset while results are in flight.
        run_job(6, 1, 1, 0, 0, 0, 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
